// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle for alu_seq_core.
// The master side offers operations and consumes results. The slave side is the ALU core.
interface alu_seq_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_err;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, hi, flag_zero, flag_carry, flag_err, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, hi, flag_zero, flag_carry, flag_err, busy
    );
endinterface

// File: rtl/alu_seq_core.sv
// Multi-cycle WIDTH-bit ALU: single-cycle add/sub/logic, iterative restoring divide.
// Define ALU_MUL_EN to build the combinational multiplier for opcode 010.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    alu_seq_core_if.slave   bus
);
    localparam int CW = ($clog2(WIDTH + 1) < 4) ? 4 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_carry;
    logic             r_err;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvsr;
    logic [CW-1:0]    r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_div_go;
    logic             w_div_last;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_carry;
    logic             w_err;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

    assign w_in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_div_go   = (bus.op == OP_DIV) && (bus.b != '0);
    assign w_div_last = (r_state == S_DIV) && (r_cnt == LAST);

    // The shifted partial remainder is always below twice the divisor, so the
    // sign bit of the trial subtraction alone decides the quotient bit.
    assign w_shift    = {r_rem, r_quot[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_q_bit    = !w_trial[WIDTH];
    assign w_rem_nxt  = w_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_q_bit};

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif

    always_comb begin
        w_res   = '0;
        w_hi    = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (bus.op)
            OP_ADD: {w_carry, w_res} = {1'b0, bus.a} + {1'b0, bus.b};
            OP_SUB: begin
                w_res   = bus.a - bus.b;
                w_carry = (bus.a < bus.b);
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                {w_hi, w_res} = w_prod;
                w_carry       = (w_prod[2*WIDTH-1:WIDTH] != '0);
            end
`endif
            // Only loaded from IDLE for a zero divisor; legal divides take the DIV path.
            OP_DIV: begin
                w_res = '1;
                w_hi  = bus.a;
                w_err = 1'b1;
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_div_go ? S_DIV : S_DONE;
            S_DIV:  if (r_cnt == LAST) w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            if (w_div_go) begin
                r_rem  <= '0;
                r_quot <= bus.a;
                r_dvsr <= bus.b;
                r_cnt  <= '0;
            end else begin
                r_result <= w_res;
                r_hi     <= w_hi;
                r_zero   <= (w_res == '0);
                r_carry  <= w_carry;
                r_err    <= w_err;
            end
        end else if (r_state == S_DIV) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_div_last) begin
                r_result <= w_quot_nxt;
                r_hi     <= w_rem_nxt;
                r_zero   <= (w_quot_nxt == '0);
                r_carry  <= 1'b0;
                r_err    <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.result     = r_result;
    assign bus.hi         = r_hi;
    assign bus.flag_zero  = r_zero;
    assign bus.flag_carry = r_carry;
    assign bus.flag_err   = r_err;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core at WIDTH=8; expectations follow ALU_MUL_EN when defined.
module tb_alu_seq_core;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_core_if #(.WIDTH(W)) bus ();

    alu_seq_core #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] h;
        logic         z;
        logic         c;
        logic         e;
    } exp_t;

    exp_t q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Offer one op, queue its expected result, then measure accept-to-out_valid latency.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic [W-1:0] eh,
                        input logic ez, input logic ec, input logic ee,
                        input int lat, input bit is_div);
        int   n;
        bit   ready_seen;
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.in_ready && n < 20);
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        e.r = er; e.h = eh; e.z = ez; e.c = ec; e.e = ee;
        q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a  = W'($urandom);
        bus.b  = W'($urandom);
        bus.op = 3'($urandom_range(0, 7));
        n = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.out_valid && bus.in_ready) ready_seen = 1'b1;
        end while (!bus.out_valid && n < 40);
        chk("latency", n, lat);
        if (is_div) chk("div_in_ready_low", ready_seen, 0);
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    m = q.pop_front();
                    chk("result", bus.result, m.r);
                    chk("hi", bus.hi, m.h);
                    chk("flag_zero", bus.flag_zero, m.z);
                    chk("flag_carry", bus.flag_carry, m.c);
                    chk("flag_err", bus.flag_err, m.e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_flags", {bus.flag_zero, bus.flag_carry, bus.flag_err}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        send(3'b000, 8'd200, 8'd100, 8'd44,  8'd0,   0, 1, 0, 1, 0);
        send(3'b001, 8'd5,   8'd7,   8'd254, 8'd0,   0, 1, 0, 1, 0);
        send(3'b001, 8'd9,   8'd9,   8'd0,   8'd0,   1, 0, 0, 1, 0);
        send(3'b000, 8'd255, 8'd1,   8'd0,   8'd0,   1, 1, 0, 1, 0);
`ifdef ALU_MUL_EN
        send(3'b010, 8'd200, 8'd200, 8'h40,  8'h9C,  0, 1, 0, 1, 0);
        send(3'b010, 8'd15,  8'd17,  8'd255, 8'd0,   0, 0, 0, 1, 0);
`else
        send(3'b010, 8'd200, 8'd200, 8'd0,   8'd0,   1, 0, 1, 1, 0);
        send(3'b010, 8'd15,  8'd17,  8'd0,   8'd0,   1, 0, 1, 1, 0);
`endif
        send(3'b011, 8'd200, 8'd7,   8'd28,  8'd4,   0, 0, 0, 9, 1);
        send(3'b011, 8'd255, 8'd1,   8'd255, 8'd0,   0, 0, 0, 9, 1);
        send(3'b011, 8'd5,   8'd9,   8'd0,   8'd5,   1, 0, 0, 9, 1);
        send(3'b011, 8'd37,  8'd0,   8'd255, 8'd37,  0, 0, 1, 1, 0);
        send(3'b111, 8'd12,  8'd34,  8'd0,   8'd0,   1, 0, 1, 1, 0);
        send(3'b100, 8'hF0,  8'h3C,  8'h30,  8'd0,   0, 0, 0, 1, 0);
        send(3'b101, 8'hA0,  8'h05,  8'hA5,  8'd0,   0, 0, 0, 1, 0);
        send(3'b110, 8'hFF,  8'hFF,  8'd0,   8'd0,   1, 0, 0, 1, 0);

        // Back-pressure: result must hold while new offers are refused.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(3'b000, 8'd3, 8'd4, 8'd7, 8'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            bus.op = 3'($urandom_range(0, 6));
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_result", {bus.hi, bus.result}, {8'd0, 8'd7});
            chk("hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_release_busy", bus.busy, 0);

        // Reset in the middle of a divide abandons it without a result.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = 3'b011; bus.a = 8'd200; bus.b = 8'd7;
        @(negedge clk);
        chk("rdiv_in_ready", bus.in_ready, 1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rdiv_busy", bus.busy, 1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdiv_out_valid", bus.out_valid, 0);
        chk("rdiv_busy_after", bus.busy, 0);
        chk("rdiv_result", bus.result, 0);
        chk("rdiv_hi", bus.hi, 0);
        chk("rdiv_flags", {bus.flag_zero, bus.flag_carry, bus.flag_err}, 0);
        chk("rdiv_in_ready_rst", bus.in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rdiv_no_result", seen, 0);
        send(3'b000, 8'd1, 8'd2, 8'd3, 8'd0, 0, 0, 0, 1, 0);

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, multi-cycle successor to the 4-bit single-cycle ALU in the top-level wrapper. It takes WIDTH-bit operands and an opcode over a valid/ready handshake, and returns a registered result with status flags over a second valid/ready handshake. Add, sub and logic ops complete in one cycle. Divide runs on an iterative restoring divider. The block sits between the pin-mapping wrapper and any operand sequencer, and processes one operation at a time.

## Interface
- WIDTH, 8: operand and result width; legal values are WIDTH ≥ 2.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- op  in  3  opcode.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result is held on the outputs.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  primary result.
- hi  out  WIDTH  product upper word or remainder; 0 otherwise.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  carry, borrow or product overflow.
- flag_err  out  1  divide by zero or illegal op.
- busy  out  1  state != IDLE.

## Operation
- States and transitions:
  - IDLE → DONE on accept of any op except a legal divide.
  - IDLE → DIV on accept of a divide with b != 0.
  - DIV → DONE after WIDTH iterations.
  - DONE → IDLE on out_valid && out_ready.
- Control signals:
  - Accept means in_valid && in_ready.
  - in_ready = (state == IDLE) && !rst.
  - out_valid = (state == DONE).
  - There is no overlap: a new op is not accepted in the cycle a result is popped.
- Operands and opcode are captured at accept. Later changes on a, b and op have no effect on the operation in flight.
- Opcodes (all arithmetic unsigned, modulo 2^WIDTH):
  - 000 add: carry = carry-out.
  - 001 sub: result = a−b; carry = borrow (a < b).
  - 010 mul: {hi, result} = full 2·WIDTH product; carry = (hi != 0).
  - 011 div: result = quotient, hi = remainder, carry = 0.
  - 100 and, 101 or, 110 xor: carry = 0.
  - 111 illegal: result = 0, hi = 0, err = 1.
- Divide by zero:
  - No DIV state; the block goes straight to DONE.
  - result = all ones, hi = a, err = 1, carry = 0.
- Divider behaviour:
  - One quotient bit per cycle, MSB first.
  - The partial remainder is WIDTH+1 bits wide.
  - A 4-bit or wider counter counts to WIDTH.
- flag_zero always reflects result only, never hi.
- flag_err = 0 for every legal op with b != 0.
- All outputs stay stable while out_valid && !out_ready.
- Outputs keep their last values after the pop until the next result is loaded.

## Timing
- Reset values:
  - state = IDLE.
  - result, hi, all flags, out_valid and busy = 0.
  - in_ready = 0 during reset, then 1 in the first cycle after reset is released.
- Reset mid-operation, in DIV or DONE:
  - The op is abandoned and the block returns to IDLE.
  - No out_valid is produced.
- Single-cycle ops (including divide by zero and illegal op): out_valid rises the cycle after accept. Latency is 1.
- Divide with b != 0: out_valid rises WIDTH+1 cycles after accept.
- Throughput, best case:
  - Single-cycle ops with out_ready held high: one op per 2 cycles.
  - Divide: one op per WIDTH+2 cycles.
- in_valid asserted while busy is ignored, with no side effects.

## Configuration
- ALU_MUL_EN defined:
  - Opcode 010 instantiates a WIDTH×WIDTH combinational multiplier.
  - The product is registered at DONE entry, with latency 1.
- ALU_MUL_EN undefined:
  - No multiplier logic is present.
  - Opcode 010 behaves exactly like 111: result 0, hi 0, err 1, latency 1.

## Test plan
- WIDTH=8, add a=200, b=100 → result 44, carry 1, zero 0, err 0. out_valid the cycle after accept.
- Sub a=5, b=7 → result 254, carry 1. Sub a=9, b=9 → result 0, zero 1, carry 0.
- ALU_MUL_EN defined, mul a=200, b=200:
  - Required: result 0x40, hi 0x9C, carry 1.
  - Without the macro, the same stimulus gives result 0, err 1.
- Div a=200, b=7:
  - Required: result 28, hi 4, err 0.
  - out_valid exactly 9 cycles after accept.
  - in_ready low throughout.
- Div a=37, b=0 → result 255, hi 37, err 1, latency 1. Op 111 gives result 0, err 1.
- Hold out_ready low 5 cycles with in_valid high and changing operands:
  - Outputs stay stable and no accept occurs.
  - Pulse rst during DIV: the next cycle is IDLE with out_valid 0 and all outputs 0.
